// File: rtl/alu_cmp_pkg.sv
// Shared types for the dual-slot subtract/compare unit.
// Holds op encodings, widths and the S1 payload bundle.
package alu_cmp_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_SUB  = 2'b00,
        OP_SLT  = 2'b01,
        OP_SLTU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
        logic              id;
    } s1_t;

endpackage

// File: rtl/alu_cmp_if.sv
// Two request channels and one response channel.
// master = issue slots + writeback side, slave = arbiter.
interface alu_cmp_if;
    import alu_cmp_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_ovf;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_ovf,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_ovf,
        input  rsp_ready
    );

endinterface

// File: rtl/cmp_sub32.sv
// Combinational 32-bit subtractor with signed/unsigned compare flags.
module cmp_sub32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] diff_o,
    output logic        ovf_o,
    output logic        lt_s_o,
    output logic        lt_u_o
);

    logic [32:0] sum;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
        diff_o = sum[31:0];
        ovf_o  = (a_i[31] != b_i[31]) & (diff_o[31] != a_i[31]);
        lt_s_o = diff_o[31] ^ ovf_o;
        // unsigned borrow is the inverted carry-out
        lt_u_o = ~sum[32];
    end

endmodule

// File: rtl/alu_cmp_arbiter.sv
// Round-robin share of one subtract/compare path between two slots.
// S1 holds the accepted request, S2 is the response register.
module alu_cmp_arbiter
    import alu_cmp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    alu_cmp_if.slave bus
);

    logic s1_valid_q, s1_valid_d;
    s1_t  s1_q, s1_d;
    logic s2_valid_q, s2_valid_d;
    logic rr_q, rr_d;

    logic              id_q, id_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ovf_q, ovf_d;

    logic s1_en, s2_en;
    logic gnt0, gnt1;
    logic rdy0, rdy1, hs;

    logic [DATA_W-1:0] diff;
    logic              ovf, lt_s, lt_u;

    cmp_sub32 u_sub (
        .a_i    (s1_q.a),
        .b_i    (s1_q.b),
        .diff_o (diff),
        .ovf_o  (ovf),
        .lt_s_o (lt_s),
        .lt_u_o (lt_u)
    );

    always_comb begin
        s2_en = !s2_valid_q | bus.rsp_ready;
        s1_en = !s1_valid_q | s2_en;
        gnt1  = bus.req1_valid & (!bus.req0_valid | rr_q);
        gnt0  = bus.req0_valid & !gnt1;
        rdy0  = rst_n & s1_en & gnt0;
        rdy1  = rst_n & s1_en & gnt1;
        hs    = rdy0 | rdy1;
    end

    always_comb begin
        s1_valid_d = s1_en ? hs : s1_valid_q;
        rr_d       = hs ? !gnt1 : rr_q;
        s1_d       = s1_q;
        if (rdy1) begin
            s1_d.op  = op_e'(bus.req1_op);
            s1_d.a   = bus.req1_a;
            s1_d.b   = bus.req1_b;
            s1_d.tag = bus.req1_tag;
            s1_d.id  = 1'b1;
        end else if (rdy0) begin
            s1_d.op  = op_e'(bus.req0_op);
            s1_d.a   = bus.req0_a;
            s1_d.b   = bus.req0_b;
            s1_d.tag = bus.req0_tag;
            s1_d.id  = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        id_d       = id_q;
        tag_d      = tag_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        if (s2_en && s1_valid_q) begin
            id_d  = s1_q.id;
            tag_d = s1_q.tag;
            res_d = '0;
            ovf_d = 1'b0;
            unique case (s1_q.op)
                OP_SUB: begin
                    res_d = diff;
                    ovf_d = ovf;
                end
                OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, lt_s};
                OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, lt_u};
                OP_RSVD: res_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            rr_q       <= 1'b0;
            id_q       <= 1'b0;
            tag_q      <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            tag_q      <= tag_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp_valid  = s2_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_ovf    = ovf_q;

endmodule

// File: doc/alu_cmp_arbiter.md
Name: alu_cmp_arbiter

Overview:
Shares one 32-bit subtract/compare datapath between two issue slots (slot 0, slot 1) of the superscalar pipeline. Each slot presents SUB, SLT or SLTU requests on a valid/ready channel. The block arbitrates round-robin, registers operands, computes, and returns a tagged result on one response channel with backpressure. It sits between the dual-issue decode stage and the writeback mux.

Parameters:
TAG_W, 4, width of the requester-supplied tag returned with each result
DATA_W, 32, operand and result width; only 32 is supported

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
req0_valid  in  1  slot 0 request valid
req0_ready  out  1  slot 0 request accepted this cycle
req0_op  in  2  00 SUB, 01 SLT (signed), 10 SLTU (unsigned), 11 reserved
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req0_tag  in  TAG_W  opaque tag
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as slot 0, for slot 1
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  originating slot
rsp_tag  out  TAG_W  tag of originating request
rsp_result  out  DATA_W  A-B for SUB; {31'b0, lt} for SLT/SLTU
rsp_ovf  out  1  signed overflow of A-B; forced 0 for SLT/SLTU

Behaviour:
- Reset (rst_n=0 at a clock edge): s1_valid=0, s2_valid=0, rr_ptr=0 (slot 0 has priority first). Outputs: rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_ovf=0, req0_ready=0, req1_ready=0 while rst_n=0.
- Two-stage pipeline. S1 holds the captured operands, op, tag and id. S2 is the output register that drives the rsp_* ports.
- Advance rules: s2_en = !s2_valid | rsp_ready. s1_en = !s1_valid | s2_en.
- Request ready is combinational: reqN_ready = s1_en & grantN.
- Grant:
  - Only one valid: that slot is granted.
  - Both valid: slot rr_ptr is granted.
  - rr_ptr toggles to !granted_id only on an accepted handshake (reqN_valid & reqN_ready).
  - With no handshake, rr_ptr holds.
- A request must not be dropped. Its fields are sampled only on the handshake edge.
- Compute is performed on S1 contents and registered into S2 when s2_en.
  - Latency from request handshake to rsp_valid is 2 cycles.
  - Full throughput is one result per cycle.
- Arithmetic: {borrow_n, diff} = {1'b0, A} + {1'b0, ~B} + 1. Unsigned borrow = ~carry_out.
  - ovf = (A[31] != B[31]) & (diff[31] != A[31]).
  - SLT: lt = diff[31] ^ ovf.
  - SLTU: lt = borrow.
  - Op 11 (reserved): result 0, ovf 0, still returned with its tag.
- While rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable. S1 also holds if it is full, and both reqN_ready go low.
- Full pipeline with rsp_ready asserted: accept, advance and drain all happen in the same cycle, with no bubble.
- Responses return in acceptance order.
- Reset mid-operation clears both stages. In-flight results are discarded, and requesters must reissue them.

Decomposition:
- Shared package alu_cmp_pkg holds:
  - OP_SUB=2'b00, OP_SLT=2'b01, OP_SLTU=2'b10, OP_RSVD=2'b11
  - a typedef for the S1 payload struct {op, a, b, tag, id}
- One sub-module, cmp_sub32: combinational {diff, borrow, ovf, lt_s, lt_u} from A and B.
- Arbitration, pipeline registers and the handshake logic live in alu_cmp_arbiter.

Test Plan:
- Slot 0 only, SUB A=5 B=7, tag=3, rsp_ready=1 -> two cycles later rsp_valid=1, id=0, tag=3, result=32'hFFFFFFFE, ovf=0.
- Slot 1 SLT A=32'h80000000 B=1 -> result=1, ovf=0. Same operands with SLTU -> result=0.
- SUB A=32'h7FFFFFFF B=32'hFFFFFFFF -> result=32'h80000000, ovf=1. SLT with the same operands -> result=0.
- Both slots held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. One response per cycle, in order, with matching tags.
- Two requests accepted, then rsp_ready=0 for 5 cycles -> rsp_* held stable, both reqN_ready=0, no loss. Release -> both results delivered in order.
- rst_n=0 pulsed for one cycle with S1 and S2 full -> the next cycle has rsp_valid=0 and rr_ptr=0. The following request has 2-cycle latency.
